// File: rtl/alu_op_encoder_pkg.sv
// ALU Operation types, RV32I opcode constants and the combinational decoder.
// Latency: none (package of types and pure functions).
// Backpressure: not applicable; consumed by the skid buffer and the encoder top.
package alu_op_pkg;

    // 4-bit ALU Operation code; 1011-1111 are never produced
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_LT  = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_EQ  = 4'b1000,
        ALU_NE  = 4'b1001,
        ALU_SUB = 4'b1010
    } alu_op_e;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // funct7 values that select the base / alternate (SUB, SRA) operation
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One decoded entry as carried through the skid buffer
    typedef struct packed {
        alu_op_e operation;
        logic    is_branch;
        logic    br_invert;
        logic    illegal;
    } alu_op_s;

    // Idle/reset value of the head entry: a harmless ADD
    localparam alu_op_s ALU_OP_RESET = '{operation: ALU_ADD, is_branch: 1'b0,
                                         br_invert: 1'b0, illegal: 1'b0};

    // Unsupported encodings still flow as ADD, flagged illegal
    localparam alu_op_s ALU_OP_ILLEGAL = '{operation: ALU_ADD, is_branch: 1'b0,
                                           br_invert: 1'b0, illegal: 1'b1};

    // Build a legal entry
    function automatic alu_op_s alu_mk(input alu_op_e op, input logic br, input logic inv);
        alu_op_s res;
        res.operation = op;
        res.is_branch = br;
        res.br_invert = inv;
        res.illegal   = 1'b0;
        return res;
    endfunction

    // Shared R/I arithmetic table. For I-type funct7 is immediate bits, except
    // for the shifts where it selects logical vs arithmetic.
    function automatic alu_op_s alu_decode_arith(input logic [2:0] funct3,
                                                 input logic [6:0] funct7,
                                                 input logic       is_reg);
        alu_op_s res;
        logic    f7_base;
        logic    f7_alt;
        logic    f7_ok;
        res     = ALU_OP_ILLEGAL;
        f7_base = (funct7 == F7_BASE);
        f7_alt  = (funct7 == F7_ALT);
        f7_ok   = !is_reg || f7_base;
        case (funct3)
            3'b000: begin
                if (f7_ok)                res = alu_mk(ALU_ADD, 1'b0, 1'b0);
                else if (f7_alt)          res = alu_mk(ALU_SUB, 1'b0, 1'b0);
            end
            3'b001: if (f7_base)          res = alu_mk(ALU_SLL, 1'b0, 1'b0);
            3'b010: if (f7_ok)            res = alu_mk(ALU_LT,  1'b0, 1'b0);
            3'b100: if (f7_ok)            res = alu_mk(ALU_XOR, 1'b0, 1'b0);
            3'b101: begin
                if (f7_base)              res = alu_mk(ALU_SRL, 1'b0, 1'b0);
                else if (f7_alt)          res = alu_mk(ALU_SRA, 1'b0, 1'b0);
            end
            3'b110: if (f7_ok)            res = alu_mk(ALU_OR,  1'b0, 1'b0);
            3'b111: if (f7_ok)            res = alu_mk(ALU_AND, 1'b0, 1'b0);
            default:                      res = ALU_OP_ILLEGAL;
        endcase
        return res;
    endfunction

    // Conditional branches: BGE reuses LT with the taken sense inverted
    function automatic alu_op_s alu_decode_branch(input logic [2:0] funct3);
        alu_op_s res;
        case (funct3)
            3'b000:  res = alu_mk(ALU_EQ, 1'b1, 1'b0);
            3'b001:  res = alu_mk(ALU_NE, 1'b1, 1'b0);
            3'b100:  res = alu_mk(ALU_LT, 1'b1, 1'b0);
            3'b101:  res = alu_mk(ALU_LT, 1'b1, 1'b1);
            default: res = ALU_OP_ILLEGAL;
        endcase
        return res;
    endfunction

    // Full decode of opcode/funct3/funct7 into one entry
    function automatic alu_op_s alu_decode(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic [6:0] funct7);
        alu_op_s res;
        case (opcode)
            OP_R:      res = alu_decode_arith(funct3, funct7, 1'b1);
            OP_I:      res = alu_decode_arith(funct3, funct7, 1'b0);
            OP_BRANCH: res = alu_decode_branch(funct3);
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
                       res = alu_mk(ALU_ADD, 1'b0, 1'b0);
            default:   res = ALU_OP_ILLEGAL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_op_encoder_skid.sv
// Two-entry valid/ready skid buffer carrying decoded ALU Operation entries.
// Latency: 1 cycle from accepted input to out_valid; no combinational in->out path.
// Backpressure: in_ready is a register, low only while both entries are occupied.
module alu_op_skid
    import alu_op_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    in_valid,
    output logic    in_ready,
    input  alu_op_s in_data,
    output logic    out_valid,
    input  logic    out_ready,
    output alu_op_s out_data
);

    if (DEPTH != 2) begin : g_depth_check
        $error("alu_op_skid: DEPTH must be 2");
    end

    logic [1:0] r_count;
    logic       r_in_ready;
    logic       r_out_valid;
    alu_op_s    r_head;
    alu_op_s    r_tail;

    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_nxt;
    alu_op_s    w_head_nxt;
    alu_op_s    w_tail_nxt;

    // flush overrides both sides of the handshake
    assign w_push = in_valid && r_in_ready && !flush;
    assign w_pop  = r_out_valid && out_ready && !flush;

    // Next occupancy and entry contents; head only changes on a pop or fill from empty
    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        if (flush) begin
            w_count_nxt = 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        w_head_nxt  = in_data;
                        w_count_nxt = 2'd1;
                    end
                end
                2'd1: begin
                    case ({w_push, w_pop})
                        2'b11: w_head_nxt = in_data;
                        2'b10: begin
                            w_tail_nxt  = in_data;
                            w_count_nxt = 2'd2;
                        end
                        2'b01: w_count_nxt = 2'd0;
                        default: w_count_nxt = r_count;
                    endcase
                end
                2'd2: begin
                    // in_ready is low here, so only a pop can happen
                    if (w_pop) begin
                        w_head_nxt  = r_tail;
                        w_count_nxt = 2'd1;
                    end
                end
                default: w_count_nxt = 2'd0;
            endcase
        end
    end

    // State register; ready/valid are registered copies of the next occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head      <= ALU_OP_RESET;
            r_tail      <= ALU_OP_RESET;
        end else begin
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head;

endmodule

// File: rtl/alu_op_encoder.sv
// Decodes RV32I opcode/funct3/funct7 into the ALU Operation code and branch qualifiers.
// Latency: 1 cycle, result leaves from a register; no combinational in->out path.
// Backpressure: 2-entry skid buffer; in_ready is registered and drops only when full.
module alu_op_encoder
    import alu_op_pkg::*;
#(
    parameter int OPCODE_LENGTH = 4,
    parameter int DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] out_operation,
    output logic                     out_is_branch,
    output logic                     out_br_invert,
    output logic                     out_illegal
);

    if (OPCODE_LENGTH != 4) begin : g_width_check
        $error("alu_op_encoder: OPCODE_LENGTH must be 4");
    end

    alu_op_s w_decoded;
    alu_op_s w_head;

    // Pure decode of the incoming fields; captured by the skid buffer on push
    always_comb begin
        w_decoded = alu_decode(in_opcode, in_funct3, in_funct7);
    end

    alu_op_skid #(
        .DEPTH(DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_decoded),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_head)
    );

    assign out_operation = w_head.operation;
    assign out_is_branch = w_head.is_branch;
    assign out_br_invert = w_head.br_invert;
    assign out_illegal   = w_head.illegal;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Bench for alu_op_encoder: directed scenarios plus randomized traffic against a
// table-driven decode reference and a queue model of the buffer.
module tb_alu_op_encoder;

    localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_XOR = 4'd3,
                           C_SLL = 4'd4, C_SRL = 4'd5, C_LT = 4'd6, C_SRA = 4'd7,
                           C_EQ = 4'd8, C_NE = 4'd9, C_SUB = 4'd10;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [6:0] in_opcode, in_funct7;
    logic [2:0] in_funct3;
    logic [3:0] out_operation;
    logic       out_is_branch, out_br_invert, out_illegal;

    always #5 clk = ~clk;

    alu_op_encoder #(.OPCODE_LENGTH(4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operation(out_operation), .out_is_branch(out_is_branch),
        .out_br_invert(out_br_invert), .out_illegal(out_illegal)
    );

    typedef struct { logic [3:0] op; logic br; logic inv; logic ill; } exp_t;
    // f3/f7 of -1 means "any value"
    typedef struct { logic [6:0] opc; int f3; int f7; logic [3:0] op; logic br; logic inv; } rule_t;

    rule_t rules[$];
    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic void add_rule(logic [6:0] o, int f3, int f7, logic [3:0] op, logic br, logic inv);
        rule_t r;
        r.opc = o; r.f3 = f3; r.f7 = f7; r.op = op; r.br = br; r.inv = inv;
        rules.push_back(r);
    endfunction

    function automatic void build_rules();
        // R-type
        add_rule(7'h33, 0, 'h00, C_ADD, 0, 0); add_rule(7'h33, 0, 'h20, C_SUB, 0, 0);
        add_rule(7'h33, 1, 'h00, C_SLL, 0, 0); add_rule(7'h33, 2, 'h00, C_LT,  0, 0);
        add_rule(7'h33, 4, 'h00, C_XOR, 0, 0); add_rule(7'h33, 5, 'h00, C_SRL, 0, 0);
        add_rule(7'h33, 5, 'h20, C_SRA, 0, 0); add_rule(7'h33, 6, 'h00, C_OR,  0, 0);
        add_rule(7'h33, 7, 'h00, C_AND, 0, 0);
        // I-type: funct7 only matters for shifts
        add_rule(7'h13, 0, -1, C_ADD, 0, 0);   add_rule(7'h13, 1, 'h00, C_SLL, 0, 0);
        add_rule(7'h13, 2, -1, C_LT, 0, 0);    add_rule(7'h13, 4, -1, C_XOR, 0, 0);
        add_rule(7'h13, 5, 'h00, C_SRL, 0, 0); add_rule(7'h13, 5, 'h20, C_SRA, 0, 0);
        add_rule(7'h13, 6, -1, C_OR, 0, 0);    add_rule(7'h13, 7, -1, C_AND, 0, 0);
        // address/link group
        add_rule(7'h03, -1, -1, C_ADD, 0, 0);  add_rule(7'h23, -1, -1, C_ADD, 0, 0);
        add_rule(7'h6F, -1, -1, C_ADD, 0, 0);  add_rule(7'h67, -1, -1, C_ADD, 0, 0);
        add_rule(7'h37, -1, -1, C_ADD, 0, 0);  add_rule(7'h17, -1, -1, C_ADD, 0, 0);
        // branches
        add_rule(7'h63, 0, -1, C_EQ, 1, 0);    add_rule(7'h63, 1, -1, C_NE, 1, 0);
        add_rule(7'h63, 4, -1, C_LT, 1, 0);    add_rule(7'h63, 5, -1, C_LT, 1, 1);
    endfunction

    function automatic exp_t ref_decode(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
        exp_t r;
        r.op = C_ADD; r.br = 1'b0; r.inv = 1'b0; r.ill = 1'b1;
        foreach (rules[i]) begin
            if (rules[i].opc == opc && (rules[i].f3 < 0 || rules[i].f3 == int'(f3))
                && (rules[i].f7 < 0 || rules[i].f7 == int'(f7))) begin
                r.op = rules[i].op; r.br = rules[i].br; r.inv = rules[i].inv; r.ill = 1'b0;
                return r;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        in_valid = v; in_opcode = o; in_funct3 = f3; in_funct7 = f7;
    endtask

    // Called just after a falling edge with inputs set: check, clock once, update model
    task automatic step();
        exp_t e;
        logic push, pop;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0) begin
            chk("operation", out_operation, q[0].op);
            chk("is_branch", out_is_branch, q[0].br);
            chk("br_invert", out_br_invert, q[0].inv);
            chk("illegal", out_illegal, q[0].ill);
        end
        push = in_valid && (q.size() < 2) && !flush;
        pop  = (q.size() != 0) && out_ready && !flush;
        e    = ref_decode(in_opcode, in_funct3, in_funct7);
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic rand_instr();
        logic [6:0] opcs [0:9];
        int k;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};
        k = $urandom_range(0, 10);
        in_opcode = (k == 10) ? 7'($urandom) : opcs[k];
        in_funct3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
            0:       in_funct7 = 7'h00;
            1:       in_funct7 = 7'h20;
            default: in_funct7 = 7'($urandom);
        endcase
    endtask

    initial begin
        build_rules();
        // 1: reset held with in_valid asserted
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 7'h33, 3'd0, 7'h00);
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_operation", out_operation, C_ADD);
        chk("rst_flags", {out_is_branch, out_br_invert, out_illegal}, 3'b000);
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();

        // 2: decode sweep with consumer always ready
        drive(1'b1, 7'h33, 3'd0, 7'h20); step(); in_valid = 1'b0;
        chk("t2_sub", out_operation, C_SUB); step();
        drive(1'b1, 7'h13, 3'd5, 7'h20); step(); in_valid = 1'b0;
        chk("t2_srai", out_operation, C_SRA); step();
        drive(1'b1, 7'h63, 3'd5, 7'h00); step(); in_valid = 1'b0;
        chk("t2_bge", {out_operation, out_is_branch, out_br_invert}, {C_LT, 2'b11}); step();
        drive(1'b1, 7'h63, 3'd6, 7'h00); step(); in_valid = 1'b0;
        chk("t2_b110", {out_operation, out_illegal, out_is_branch}, {C_ADD, 2'b10}); step();

        // 3: backpressure fills both entries, third push refused
        out_ready = 1'b0;
        drive(1'b1, 7'h33, 3'd0, 7'h20); step();
        drive(1'b1, 7'h33, 3'd4, 7'h00); step();
        chk("t3_full", in_ready, 1'b0);
        drive(1'b1, 7'h33, 3'd7, 7'h00); step(); step();
        in_valid = 1'b0; out_ready = 1'b1;
        chk("t3_first", out_operation, C_SUB); step();
        chk("t3_second", out_operation, C_XOR); step();
        chk("t3_empty", {out_valid, in_ready}, 2'b01);

        // 4: push and pop every cycle at occupancy 1
        out_ready = 1'b0;
        drive(1'b1, 7'h33, 3'd6, 7'h00); step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_stream_valid", out_valid, 1'b1);
            step();
        end
        chk("t4_occ1", {out_valid, in_ready}, 2'b11);
        in_valid = 1'b0; step(); step();

        // 5: flush at occupancy 2 with a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 7'h33, 3'd1, 7'h00); step();
        drive(1'b1, 7'h13, 3'd2, 7'h00); step();
        drive(1'b1, 7'h63, 3'd0, 7'h00); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("t5_flushed", {out_valid, in_ready}, 2'b01);
        repeat (3) step();

        // 6: asynchronous reset between edges at occupancy 2
        out_ready = 1'b0;
        drive(1'b1, 7'h33, 3'd5, 7'h20); step();
        drive(1'b1, 7'h33, 3'd6, 7'h00); step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("t6_async_valid", out_valid, 1'b0);
        chk("t6_async_ready", in_ready, 1'b1);
        q.delete();
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) step();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rand_instr();
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
